// File: rtl/control_pkg.sv
// Shared control-path definitions: FSM state encoding, instruction class
// codes and the bundle of datapath control outputs.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // Instruction class (op field)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // funct field bit positions
  localparam int FUNCT_I_BIT = 5;  // immediate operand
  localparam int FUNCT_L_BIT = 0;  // load (memory) / set-flags (data-processing)

  // ALU B operand select
  localparam logic [1:0] ALUB_REG = 2'b00;
  localparam logic [1:0] ALUB_IMM = 2'b01;
  localparam logic [1:0] ALUB_4   = 2'b10;

  // Result select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
  } ctrl_t;

  // Strip the side-effecting strobes (register/memory/PC writes).
  function automatic ctrl_t ctrl_quiet(input ctrl_t c);
    ctrl_t r;
    r         = c;
    r.irwrite = 1'b0;
    r.nextpc  = 1'b0;
    r.regw    = 1'b0;
    r.memw    = 1'b0;
    r.branch  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/main_fsm_controller_if.sv
// Instruction-in / control-out bundle of the main controller. The master
// side presents the instruction fields, the slave side returns controls.
interface main_fsm_controller_if;
  import control_pkg::*;

  logic [1:0] op;
  logic [5:0] funct;
  logic       irwrite;
  logic       adrsrc;
  logic       alusrca;
  logic       nextpc;
  logic       regw;
  logic       memw;
  logic       branch;
  logic       aluop;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic [3:0] state_dbg;

  modport master (
    output op, funct,
    input  irwrite, adrsrc, alusrca, nextpc, regw, memw, branch, aluop,
    input  alusrcb, resultsrc, state_dbg
  );

  modport slave (
    input  op, funct,
    output irwrite, adrsrc, alusrca, nextpc, regw, memw, branch, aluop,
    output alusrcb, resultsrc, state_dbg
  );

endinterface

// File: rtl/main_fsm_controller.sv
// Multicycle processor main controller: Moore FSM sequencing fetch, decode,
// memory, execute, write-back and branch steps, with a programmable number
// of instruction-memory wait cycles in FETCH.
module main_fsm_controller
  import control_pkg::*;
#(
  parameter int unsigned FETCH_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  output logic       irwrite,
  output logic       adrsrc,
  output logic       alusrca,
  output logic       nextpc,
  output logic       regw,
  output logic       memw,
  output logic       branch,
  output logic       aluop,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] WAIT_LAST = 4'(FETCH_WAIT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       fetch_done;
  ctrl_t      ctl, ctl_o;

  // The instruction word is ready on the last wait cycle of FETCH.
  assign fetch_done = (cnt_q == WAIT_LAST);

  // State and wait-count registers; reset lands in FETCH with a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-count logic; op/funct are only looked at in DECODE/MEMADR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        if (fetch_done) begin
          state_d = S_DECODE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DECODE: begin
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[FUNCT_I_BIT] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;  // illegal: drop it and fetch the next one
        endcase
      end
      S_MEMADR:   state_d = funct[FUNCT_L_BIT] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;  // MEMWB, MEMWR, ALUWB, BRANCH, unused codes
    endcase
  end

  // Moore output decode from state and wait count only.
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.alusrca   = 1'b1;
        ctl.alusrcb   = ALUB_4;
        ctl.resultsrc = RES_ALU;
        ctl.irwrite   = fetch_done;
        ctl.nextpc    = fetch_done;
      end
      S_DECODE: begin
        ctl.alusrca   = 1'b1;
        ctl.alusrcb   = ALUB_4;
        ctl.resultsrc = RES_ALU;
      end
      S_MEMADR:   ctl.alusrcb = ALUB_IMM;
      S_MEMRD:    ctl.adrsrc  = 1'b1;
      S_MEMWB: begin
        ctl.resultsrc = RES_DATA;
        ctl.regw      = 1'b1;
      end
      S_MEMWR: begin
        ctl.adrsrc = 1'b1;
        ctl.memw   = 1'b1;
      end
      S_EXECUTER: ctl.aluop = 1'b1;
      S_EXECUTEI: begin
        ctl.alusrcb = ALUB_IMM;
        ctl.aluop   = 1'b1;
      end
      S_ALUWB:    ctl.regw = 1'b1;
      S_BRANCH: begin
        ctl.alusrcb   = ALUB_IMM;
        ctl.resultsrc = RES_ALU;
        ctl.branch    = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  // While reset is held the state already reads FETCH, but the strobes must
  // stay quiet even though FETCH with a zero wait would raise irwrite/nextpc.
  always_comb begin
    ctl_o = ctl;
    if (!rst_n) ctl_o = ctrl_quiet(ctl);
  end

  assign irwrite   = ctl_o.irwrite;
  assign adrsrc    = ctl_o.adrsrc;
  assign alusrca   = ctl_o.alusrca;
  assign nextpc    = ctl_o.nextpc;
  assign regw      = ctl_o.regw;
  assign memw      = ctl_o.memw;
  assign branch    = ctl_o.branch;
  assign aluop     = ctl_o.aluop;
  assign alusrcb   = ctl_o.alusrcb;
  assign resultsrc = ctl_o.resultsrc;
  assign state_dbg = state_q;

endmodule

// File: doc/main_fsm_controller.md
MAIN_FSM_CONTROLLER -- requirements
Module: main_fsm_controller

Interface
REQ-001 SHALL have parameter: FETCH_WAIT, default 0, number of extra instruction-memory wait cycles spent in FETCH before the instruction register is loaded (legal range 0..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 illegal.
REQ-005 SHALL have port: funct  input  6  instruction function field: funct[5] immediate (I) bit, funct[0] load (L) / set-flags (S) bit.
REQ-006 SHALL have ports, each output 1: irwrite, adrsrc, alusrca, nextpc, regw, memw, branch, aluop.
REQ-007 SHALL have ports, each output 2: alusrcb, resultsrc.
REQ-008 SHALL have port: state_dbg  output  4  current state encoding.

Function
REQ-009 SHALL implement a Moore FSM with states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
REQ-010 SHALL, in FETCH, count wait cycles from 0 to FETCH_WAIT, holding FETCH until the count equals FETCH_WAIT, then go to DECODE and clear the count.
REQ-011 SHALL go from DECODE to: MEMADR if op=01; EXECUTEI if op=00 and funct[5]=1; EXECUTER if op=00 and funct[5]=0; BRANCH if op=10; FETCH if op=11.
REQ-012 SHALL go from MEMADR to MEMRD if funct[0]=1, otherwise to MEMWR.
REQ-013 SHALL go: MEMRD->MEMWB; EXECUTER->ALUWB; EXECUTEI->ALUWB; and MEMWB, MEMWR, ALUWB and BRANCH->FETCH.
REQ-014 SHALL drive every output not listed for a state as 0.
REQ-015 SHALL drive in FETCH: alusrca=1, alusrcb=10, resultsrc=10; irwrite=1 and nextpc=1 only in the cycle where the count equals FETCH_WAIT.
REQ-016 SHALL drive in DECODE: alusrca=1, alusrcb=10, resultsrc=10.
REQ-017 SHALL drive in MEMADR: alusrcb=01.
REQ-018 SHALL drive in MEMRD: adrsrc=1.
REQ-019 SHALL drive in MEMWB: resultsrc=01, regw=1.
REQ-020 SHALL drive in MEMWR: adrsrc=1, memw=1.
REQ-021 SHALL drive in EXECUTER: aluop=1.
REQ-022 SHALL drive in EXECUTEI: alusrcb=01, aluop=1.
REQ-023 SHALL drive in ALUWB: regw=1.
REQ-024 SHALL drive in BRANCH: alusrcb=01, resultsrc=10, branch=1.
REQ-025 SHALL derive outputs only from state and wait count (no combinational path from op/funct to outputs).
REQ-026 SHALL sample op/funct only in DECODE and MEMADR; changes in other states SHALL have no effect.
REQ-027 SHALL give instruction latency, with W=FETCH_WAIT: load W+5, store W+4, data-processing W+4, branch W+3, illegal W+2 cycles.
REQ-028 SHALL assert at most one of regw, memw, branch in any cycle.

Reset
REQ-029 SHALL, on rst_n low, immediately force state FETCH and wait count 0, independent of clk.
REQ-030 SHALL hold irwrite, nextpc, regw, memw and branch at 0 while rst_n is low; other outputs SHALL take their FETCH values.
REQ-031 SHALL abandon any instruction if reset is asserted mid-sequence (e.g. in MEMWR) with no further memw/regw pulse; the first cycle after release SHALL be FETCH with count 0.

Structure
REQ-032 SHALL take the state enumeration and op class constants (OP_DP, OP_MEM, OP_BR) from shared package control_pkg.
REQ-033 SHALL keep the fetch wait counter inline; no sub-module is required.

Verification
REQ-034 SHALL be verified by: FETCH_WAIT=0, op=01, funct=000001 -> states 0,1,2,3,4,0; regw=1 only in MEMWB with resultsrc=01.
REQ-035 SHALL be verified by: op=01, funct=000000 -> states 0,1,2,5,0; memw=1 for exactly one cycle with adrsrc=1.
REQ-036 SHALL be verified by: op=00, funct=100000, then funct=000000 -> EXECUTEI (alusrcb=01, aluop=1), then EXECUTER (alusrcb=00, aluop=1), each followed by ALUWB.
REQ-037 SHALL be verified by: FETCH_WAIT=3 -> FETCH held 4 cycles; irwrite and nextpc high only in the 4th.
REQ-038 SHALL be verified by: op=11 -> DECODE returns to FETCH with no regw, memw or branch pulse.
REQ-039 SHALL be verified by: rst_n dropped mid-MEMWR between clock edges -> state_dbg=0 immediately; memw=0; after release FETCH resumes.
